// File: rtl/axis_velocity_ctrl.sv
// Per-axis velocity stage: integrates thrust commands into a saturating signed velocity
// once per physics tick and emits a sign/magnitude delta to the position accumulator.
module axis_velocity_ctrl #(
    parameter int W        = 16,
    parameter int TICK_DIV = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd,
    input  logic [3:0]          cmd_mag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_mode,
    output logic [W-1:0]        out_delta,
    output logic signed [W-1:0] velocity,
    output logic                sat,
    output logic [1:0]          state
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
    localparam logic signed [W:0] VMAX = {2'b00, {(W-1){1'b1}}};
    localparam logic signed [W:0] VMIN = -VMAX;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCEL = 2'd1,
        COAST = 2'd2,
        BRAKE = 2'd3
    } state_t;

    state_t                r_state;
    logic [CW-1:0]         r_count;
    logic signed [W-1:0]   r_velocity;
    logic [3:0]            r_mag;
    logic                  r_neg;
    logic                  r_sat;
    logic                  r_outValid;
    logic                  r_outMode;
    logic [W-1:0]          r_outDelta;

    logic                  w_tick;
    logic                  w_accept;
    logic signed [W:0]     w_vExt;
    logic signed [W:0]     w_magExt;
    logic signed [W:0]     w_sum;
    logic [W-1:0]          w_absV;
    logic [W-1:0]          w_brakeMag;
    logic [W-1:0]          w_rem;
    logic signed [W-1:0]   w_vNext;
    logic [W-1:0]          w_absNext;
    logic                  w_clamped;
    logic                  w_brakeDone;
    logic signed [W-1:0]   w_vAfter;

    assign w_tick    = (r_count == LAST) && (!r_outValid || out_ready);
    assign cmd_ready = !rst && (r_state != BRAKE);
    assign w_accept  = cmd_valid && cmd_ready;

    // Next velocity for a tick, always computed from the pre-acceptance state and magnitude.
    always_comb begin
        w_vExt      = {r_velocity[W-1], r_velocity};
        w_magExt    = signed'({{(W-3){1'b0}}, r_mag});
        w_sum       = w_vExt;
        w_absV      = r_velocity[W-1] ? W'(-r_velocity) : W'(r_velocity);
        w_brakeMag  = (r_mag == 4'd0) ? W'(1) : W'(r_mag);
        w_rem       = '0;
        w_vNext     = r_velocity;
        w_clamped   = 1'b0;
        w_brakeDone = 1'b0;
        case (r_state)
            ACCEL: begin
                w_sum = r_neg ? (w_vExt - w_magExt) : (w_vExt + w_magExt);
                if (w_sum > VMAX) begin
                    w_vNext   = VMAX[W-1:0];
                    w_clamped = 1'b1;
                end else if (w_sum < VMIN) begin
                    w_vNext   = VMIN[W-1:0];
                    w_clamped = 1'b1;
                end else begin
                    w_vNext = w_sum[W-1:0];
                end
            end
            BRAKE: begin
                if (w_absV <= w_brakeMag) begin
                    w_vNext     = '0;
                    w_brakeDone = 1'b1;
                end else begin
                    w_rem   = w_absV - w_brakeMag;
                    w_vNext = r_velocity[W-1] ? signed'(-w_rem) : signed'(w_rem);
                end
            end
            default: w_vNext = r_velocity;
        endcase
        w_absNext = w_vNext[W-1] ? W'(-w_vNext) : W'(w_vNext);
        w_vAfter  = w_tick ? w_vNext : r_velocity;
    end

    // A command accepted on a tick edge overrides any tick-driven state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_velocity <= '0;
            r_mag      <= '0;
            r_neg      <= 1'b0;
            r_sat      <= 1'b0;
            r_outValid <= 1'b0;
            r_outMode  <= 1'b0;
            r_outDelta <= '0;
        end else begin
            if (r_count == LAST) begin
                if (w_tick) r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end

            if (w_tick) begin
                r_velocity <= w_vNext;
                r_sat      <= w_clamped;
                r_outValid <= 1'b1;
                r_outDelta <= w_absNext;
                r_outMode  <= w_vNext[W-1];
                if (w_brakeDone) r_state <= IDLE;
            end else if (out_ready) begin
                r_outValid <= 1'b0;
            end

            if (w_accept) begin
                r_mag <= cmd_mag;
                case (cmd)
                    2'b01: begin
                        r_state <= ACCEL;
                        r_neg   <= 1'b0;
                    end
                    2'b10: begin
                        r_state <= ACCEL;
                        r_neg   <= 1'b1;
                    end
                    2'b00:   r_state <= (w_vAfter != '0) ? COAST : IDLE;
                    default: r_state <= (w_vAfter != '0) ? BRAKE : IDLE;
                endcase
            end
        end
    end

    assign out_valid = r_outValid;
    assign out_mode  = r_outMode;
    assign out_delta = r_outDelta;
    assign velocity  = r_velocity;
    assign sat       = r_sat;
    assign state     = r_state;

endmodule

// File: tb/tb_axis_velocity_ctrl.sv
// Directed bench for axis_velocity_ctrl: hand-computed velocities, deltas, states and tick timing
// for accumulation, sign crossing, backpressure, braking, saturation and reset mid-handshake.
module tb_axis_velocity_ctrl;

    localparam int W        = 16;
    localparam int TICK_DIV = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          cmdValid = 1'b0;
    logic [1:0]    cmdCode = 2'b00;
    logic [3:0]    cmdMag = 4'd0;
    logic          outReady = 1'b1;
    logic          cmdReady;
    logic          outValid;
    logic          outMode;
    logic [W-1:0]  outDelta;
    logic [W-1:0]  velocity;
    logic          sat;
    logic [1:0]    state;

    int errors = 0;
    int checks = 0;

    axis_velocity_ctrl #(.W(W), .TICK_DIV(TICK_DIV)) dut (
        .clk       (clock),
        .rst       (reset),
        .cmd_valid (cmdValid),
        .cmd_ready (cmdReady),
        .cmd       (cmdCode),
        .cmd_mag   (cmdMag),
        .out_valid (outValid),
        .out_ready (outReady),
        .out_mode  (outMode),
        .out_delta (outDelta),
        .velocity  (velocity),
        .sat       (sat),
        .state     (state)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [1:0] code, input logic [3:0] mag);
        cmdValid = valid;
        cmdCode  = code;
        cmdMag   = mag;
    endtask

    task automatic sendCmd(input string tag, input logic [1:0] code, input logic [3:0] mag);
        checkOutput({tag, " cmdReady"}, 32'(cmdReady), 32'd1);
        applyStimulus(1'b1, code, mag);
        step();
        applyStimulus(1'b0, 2'b00, 4'd0);
    endtask

    task automatic waitOut(input string tag, output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (!outValid && cycles < 40);
        checkOutput({tag, " outValid"}, 32'(outValid), 32'd1);
    endtask

    task automatic checkPulse(input string tag, input logic [15:0] expVel, input logic expMode,
                              input logic [15:0] expDelta);
        checkOutput({tag, " velocity"}, 32'(velocity), 32'(expVel));
        checkOutput({tag, " mode"}, 32'(outMode), 32'(expMode));
        checkOutput({tag, " delta"}, 32'(outDelta), 32'(expDelta));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cyc;

        // Reset and first idle emission
        step();
        step();
        checkOutput("rst cmdReady", 32'(cmdReady), 32'd0);
        checkOutput("rst velocity", 32'(velocity), 32'd0);
        checkOutput("rst state", 32'(state), 32'd0);
        checkOutput("rst outValid", 32'(outValid), 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("post-rst cmdReady", 32'(cmdReady), 32'd1);
        waitOut("first", cyc);
        checkOutput("first latency", 32'(cyc), 32'd4);
        checkPulse("idle", 16'd0, 1'b0, 16'd0);

        // Thrust+ accumulation
        sendCmd("thr+3", 2'b01, 4'd3);
        checkOutput("accel state", 32'(state), 32'd1);
        waitOut("acc1", cyc);
        checkOutput("acc1 latency", 32'(cyc), 32'd3);
        checkPulse("acc1", 16'd3, 1'b0, 16'd3);
        waitOut("acc2", cyc);
        checkOutput("acc2 period", 32'(cyc), 32'd4);
        checkPulse("acc2", 16'd6, 1'b0, 16'd6);
        waitOut("acc3", cyc);
        checkOutput("acc3 period", 32'(cyc), 32'd4);
        checkPulse("acc3", 16'd9, 1'b0, 16'd9);

        // Sign crossing
        sendCmd("thr-3", 2'b10, 4'd3);
        waitOut("dec1", cyc);
        checkPulse("dec1", 16'd6, 1'b0, 16'd6);
        sendCmd("thr-4", 2'b10, 4'd4);
        waitOut("cross1", cyc);
        checkPulse("cross1", 16'd2, 1'b0, 16'd2);
        waitOut("cross2", cyc);
        checkPulse("cross2", 16'hFFFE, 1'b1, 16'd2);
        waitOut("cross3", cyc);
        checkPulse("cross3", 16'hFFFA, 1'b1, 16'd6);

        // Backpressure: delta and velocity frozen while the slot is blocked
        outReady = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            checkOutput("bp outValid", 32'(outValid), 32'd1);
            checkOutput("bp velocity", 32'(velocity), 32'hFFFA);
        end
        checkOutput("bp delta", 32'(outDelta), 32'd6);
        outReady = 1'b1;
        step();
        checkOutput("release outValid", 32'(outValid), 32'd1);
        checkPulse("release", 16'hFFF6, 1'b1, 16'd10);
        waitOut("after release", cyc);
        checkOutput("after release period", 32'(cyc), 32'd4);
        checkPulse("after release", 16'hFFF2, 1'b1, 16'd14);
        checkOutput("accel sat", 32'(sat), 32'd0);

        // Brake from -7 with a command offered during BRAKE
        sendCmd("thr+7", 2'b01, 4'd7);
        waitOut("to -7", cyc);
        checkPulse("to -7", 16'hFFF9, 1'b1, 16'd7);
        sendCmd("brake3", 2'b11, 4'd3);
        checkOutput("brake state", 32'(state), 32'd3);
        checkOutput("brake cmdReady", 32'(cmdReady), 32'd0);
        applyStimulus(1'b1, 2'b01, 4'd2);
        waitOut("brk1", cyc);
        checkPulse("brk1", 16'hFFFC, 1'b1, 16'd4);
        checkOutput("brk1 state", 32'(state), 32'd3);
        checkOutput("brk1 cmdReady", 32'(cmdReady), 32'd0);
        waitOut("brk2", cyc);
        checkPulse("brk2", 16'hFFFF, 1'b1, 16'd1);
        checkOutput("brk2 state", 32'(state), 32'd3);
        waitOut("brk3", cyc);
        checkPulse("brk3", 16'd0, 1'b0, 16'd0);
        checkOutput("brk3 state", 32'(state), 32'd0);
        checkOutput("brk3 cmdReady", 32'(cmdReady), 32'd1);
        step();
        applyStimulus(1'b0, 2'b00, 4'd0);
        checkOutput("post-brake accept state", 32'(state), 32'd1);
        waitOut("post-brake", cyc);
        checkOutput("post-brake latency", 32'(cyc), 32'd3);
        checkPulse("post-brake", 16'd2, 1'b0, 16'd2);

        // Saturation: climb to 32762, then 32765, then clamp at 32767
        sendCmd("thr+15", 2'b01, 4'd15);
        for (int i = 0; i < 2184; i++) waitOut("climb", cyc);
        checkPulse("climb", 16'd32762, 1'b0, 16'd32762);
        checkOutput("climb sat", 32'(sat), 32'd0);
        sendCmd("thr+3b", 2'b01, 4'd3);
        waitOut("pre-sat", cyc);
        checkPulse("pre-sat", 16'd32765, 1'b0, 16'd32765);
        checkOutput("pre-sat sat", 32'(sat), 32'd0);
        sendCmd("thr+5", 2'b01, 4'd5);
        waitOut("sat1", cyc);
        checkPulse("sat1", 16'd32767, 1'b0, 16'd32767);
        checkOutput("sat1 sat", 32'(sat), 32'd1);
        waitOut("sat2", cyc);
        checkPulse("sat2", 16'd32767, 1'b0, 16'd32767);
        checkOutput("sat2 sat", 32'(sat), 32'd1);
        sendCmd("coast", 2'b00, 4'd0);
        checkOutput("coast state", 32'(state), 32'd2);
        waitOut("coast", cyc);
        checkPulse("coast", 16'd32767, 1'b0, 16'd32767);
        checkOutput("coast sat", 32'(sat), 32'd0);

        // Brake with magnitude 0 acts as magnitude 1
        sendCmd("brake0", 2'b11, 4'd0);
        checkOutput("brake0 state", 32'(state), 32'd3);
        waitOut("brk0a", cyc);
        checkPulse("brk0a", 16'd32766, 1'b0, 16'd32766);
        waitOut("brk0b", cyc);
        checkPulse("brk0b", 16'd32765, 1'b0, 16'd32765);

        // Reset while a delta is pending and blocked
        outReady = 1'b0;
        step();
        step();
        step();
        checkOutput("pending outValid", 32'(outValid), 32'd1);
        checkOutput("pending delta", 32'(outDelta), 32'd32765);
        reset = 1'b1;
        #1;
        checkOutput("mid rst cmdReady", 32'(cmdReady), 32'd0);
        step();
        checkOutput("mid rst velocity", 32'(velocity), 32'd0);
        checkOutput("mid rst state", 32'(state), 32'd0);
        checkOutput("mid rst outValid", 32'(outValid), 32'd0);
        checkOutput("mid rst delta", 32'(outDelta), 32'd0);
        checkOutput("mid rst mode", 32'(outMode), 32'd0);
        checkOutput("mid rst sat", 32'(sat), 32'd0);
        step();
        checkOutput("mid rst2 outValid", 32'(outValid), 32'd0);
        checkOutput("mid rst2 cmdReady", 32'(cmdReady), 32'd0);
        reset = 1'b0;
        outReady = 1'b1;
        #1;
        checkOutput("after rst cmdReady", 32'(cmdReady), 32'd1);
        waitOut("after rst", cyc);
        checkOutput("after rst latency", 32'(cyc), 32'd4);
        checkPulse("after rst", 16'd0, 1'b0, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axis_velocity_ctrl.md
# axis_velocity_ctrl

Per-axis velocity stage of the spaceship command module, sitting directly upstream of the axis position accumulator. It accepts thrust commands over a valid/ready handshake, integrates them into a saturating signed velocity once per physics tick, and emits a sign/magnitude delta (`out_mode`, `out_delta`) that the position stage's add/subtract datapath consumes directly. Three instances, one per axis (x, y, z), feed the spatial position block.

## Interface
- `W`, 16, velocity and delta width; velocity is two's complement.
- `TICK_DIV`, 4, clock cycles per physics tick; must be at least 2.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command can be accepted this cycle.
- `cmd`  in  2  command code: 00 coast, 01 thrust+, 10 thrust−, 11 brake.
- `cmd_mag`  in  4  acceleration magnitude per tick, unsigned 0..15.
- `out_valid`  out  1  delta available to the position stage.
- `out_ready`  in  1  position stage accepts the delta.
- `out_mode`  out  1  0 = add, 1 = subtract; sign of velocity.
- `out_delta`  out  W  |velocity|, unsigned.
- `velocity`  out  W  current signed velocity.
- `sat`  out  1  last velocity update was clamped.
- `state`  out  2  FSM state: 0 IDLE, 1 ACCEL, 2 COAST, 3 BRAKE.

## Operation
- **Command acceptance:** a command is accepted on `cmd_valid && cmd_ready`. The block latches `cmd` and `cmd_mag`.
  - `cmd_ready = !rst && state != BRAKE`, combinational.
- **Transitions**, taking effect on the edge after acceptance:
  - 01 or 10 → ACCEL, with direction latched as + or −.
  - 00 → COAST if velocity ≠ 0, otherwise IDLE.
  - 11 → BRAKE if velocity ≠ 0, otherwise IDLE.
- **Tick counter:** counts 0..TICK_DIV−1 and wraps.
  - A tick fires when `count == TICK_DIV−1 && (!out_valid || out_ready)`.
  - If the output slot is blocked, the counter holds at TICK_DIV−1 and velocity is frozen.
- **Velocity update on each tick:**
  - IDLE and COAST: unchanged.
  - ACCEL: v ± mag, computed in W+1 bits, then clamped to ±(2^(W−1)−1). The range is symmetric, so the magnitude always fits.
  - BRAKE: |v| reduced by mag, clamped at 0, sign kept. On reaching 0, state → IDLE in the same update.
  - BRAKE with mag 0: `cmd_mag` is treated as 1, so braking always terminates.
- **`sat`:** set on a tick whose ACCEL result was clamped, cleared on any unclamped tick. Otherwise held.
- **Output register:** every fired tick loads `out_delta = |v_new|` and `out_mode = (v_new < 0)`, and sets `out_valid`.
  - `out_valid` clears on `out_ready` unless a new tick fires in the same cycle.
  - While `out_valid && !out_ready`, `out_delta` and `out_mode` hold stable.
- **Emission in IDLE:** ticks are still emitted with delta 0, keeping all axes in lockstep.
- **Simultaneous tick and command acceptance:** the tick uses the pre-acceptance state and magnitude. The new command applies from the next tick.
- **Reset, including mid-operation or mid-handshake:** the pending output is dropped. Next-edge values:
  - velocity 0, state IDLE, count 0
  - `out_valid` 0, `out_delta` 0, `out_mode` 0, `sat` 0
  - `cmd_ready` is 0 while `rst` is high and 1 after it.

## Timing
- **Command to velocity:** 1 cycle from acceptance to the state change. The first velocity change lands on the next fired tick.
- **Tick to output:** `out_valid` and the updated `velocity` are visible 1 cycle after the firing-tick edge. There is no further pipeline latency.
- **Throughput:** with `out_ready` held high, one output every TICK_DIV cycles.
- **After reset:** the first `out_valid` appears TICK_DIV cycles after `rst` deasserts.
- **Output timing:** all outputs are registered except `cmd_ready`.

## Test plan
1. **Reset mid-handshake:** hold `rst` high 2 cycles while `out_valid`=1, `out_ready`=0 and v=9 → all outputs 0, state 0. `cmd_ready` is 0 during reset and 1 after.
2. **Thrust+ accumulation:** TICK_DIV=4, `out_ready`=1, thrust+ mag 3 → `out_valid` pulses every 4 cycles with delta 3, 6, 9 and mode 0.
3. **Sign crossing:** from v=6, thrust− mag 4 → velocity 2 (mode 0, delta 2), then −2 (mode 1, delta 2), then −6 (mode 1, delta 6).
4. **Saturation:** preload v=32765, thrust+ mag 5 → 32767 with `sat`=1. Next tick: 32767, `sat` stays 1. Then coast → `sat`=0 on the next tick.
5. **Backpressure:** hold `out_ready`=0 for 10 cycles during ACCEL → `out_valid` held, delta unchanged, velocity frozen. On release, delta is taken and the next tick fires on the following cycle, then every 4 cycles.
6. **Brake:** from v=−7, brake mag 3 → velocity −4, −1, 0, with state going 3 then 0 as v reaches 0. `cmd_ready` is 0 throughout BRAKE; a `cmd_valid` offered during BRAKE is not accepted until IDLE.
